// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: single write-port arbiter for the 32x32 register file.
// Merges pipeline writeback with buffered long-latency results.
module rf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    input  logic        ws_we,
    input  logic [4:0]  ws_waddr,
    input  logic [31:0] ws_wdata,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pend_mask,
    output logic        ws_hold
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          rf_we_q;
    logic          rf_we_d;
    logic [4:0]    rf_waddr_q;
    logic [4:0]    rf_waddr_d;
    logic [31:0]   rf_wdata_q;
    logic [31:0]   rf_wdata_d;

    logic          ws_take;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    // Port ownership: a real pipeline write always wins; otherwise drain the FIFO head.
    always_comb begin
        ws_take    = ws_valid & ws_we & (ws_waddr != 5'd0);
        fifo_empty = (count_q == '0);
        lu_ready   = (count_q < CW'(DEPTH));
        push       = lu_valid & lu_ready;
        pop        = ~ws_take & ~fifo_empty;
        head_addr  = fifo_addr_q[rd_ptr_q];
        head_data  = fifo_data_q[rd_ptr_q];
    end

    // Next output register, FIFO occupancy and starvation count.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        count_d    = count_q;
        starve_d   = starve_q;
        if (ws_take) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ws_waddr;
            rf_wdata_d = ws_wdata;
        end else if (pop && head_addr != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_addr;
            rf_wdata_d = head_data;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // State registers; reset flushes every buffered entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= lu_waddr;
                fifo_data_q[wr_ptr_q] <= lu_wdata;
                wr_ptr_q              <= wr_ptr_q + AW'(1);
            end
        end
    end

    // Pending destinations: live FIFO entries plus the write now on the port.
    always_comb begin
        logic [AW-1:0] idx;
        pend_mask = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q && fifo_addr_q[idx] != 5'd0) begin
                pend_mask[fifo_addr_q[idx]] = 1'b1;
            end
        end
        if (rf_we_q) begin
            pend_mask[rf_waddr_q] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign ws_hold  = (starve_q == SW'(STARVE_LIMIT));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_valid, ws_we;
    logic [4:0]  ws_waddr;
    logic [31:0] ws_wdata;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic        ws_hold;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .ws_valid(ws_valid), .ws_we(ws_we),
        .ws_waddr(ws_waddr), .ws_wdata(ws_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready),
        .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask), .ws_hold(ws_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          m_starve;

    typedef struct {
        logic        wv;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_pend;
        logic        e_rdy;
        logic        e_hold;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) if (mq[i].a != 5'd0) m[mq[i].a] = 1'b1;
        if (m_we) m[m_wa] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_we     = 1'b0;
        m_wa     = '0;
        m_wd     = '0;
        m_starve = 0;
    endtask

    task automatic m_update();
        int   pre;
        bit   take, popped;
        ent_t e;
        pre    = mq.size();
        take   = ws_valid && ws_we && ws_waddr != 5'd0;
        popped = 0;
        if (take) begin
            m_we = 1'b1; m_wa = ws_waddr; m_wd = ws_wdata;
        end else if (pre > 0) begin
            e = mq.pop_front();
            popped = 1;
            m_we = (e.a != 5'd0); m_wa = e.a; m_wd = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (popped || pre == 0) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        if (lu_valid && pre < DEPTH) begin
            e.a = lu_waddr; e.d = lu_wdata;
            mq.push_back(e);
        end
    endtask

    task automatic cmp_model();
        chk("m_rf_we", 32'(rf_we), 32'(m_we));
        if (m_we) begin
            chk("m_rf_waddr", 32'(rf_waddr), 32'(m_wa));
            chk("m_rf_wdata", rf_wdata, m_wd);
        end
        chk("m_pend", pend_mask, m_pend());
        chk("m_ready", 32'(lu_ready), 32'(mq.size() < DEPTH));
        chk("m_hold", 32'(ws_hold), 32'(m_starve == LIMIT));
    endtask

    task automatic drv(input logic wv, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic lv,
                       input logic [4:0] la, input logic [31:0] ld);
        ws_valid = wv; ws_we = we; ws_waddr = wa; ws_wdata = wd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        cmp_model();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
        chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
        chk({tag, "_ready"}, 32'(lu_ready), 32'd1);
        chk({tag, "_pend"}, pend_mask, 32'd0);
        chk({tag, "_hold"}, 32'(ws_hold), 32'd0);
    endtask

    initial begin
        logic [4:0]  a;
        logic        hold_lu;
        logic [4:0]  h_la;
        logic [31:0] h_ld;

        tbl[0] = '{1'b1, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0,
                   1'b0, 5'd0, 32'd0, 32'h0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,
                   1'b1, 5'd5, 32'h12345678, 32'h20, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5A5A5,
                   1'b0, 5'd0, 32'd0, 32'h0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                   1'b0, 5'd0, 32'd0, 32'h80, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                   1'b1, 5'd7, 32'hA5A5A5A5, 32'h80, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                   1'b0, 5'd0, 32'd0, 32'h0, 1'b1, 1'b0};

        resetn = 1'b0;
        idle();
        m_reset();
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            chk($sformatf("tbl%0d_we", i), 32'(rf_we), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                chk($sformatf("tbl%0d_waddr", i), 32'(rf_waddr),
                    32'(tbl[i].e_wa));
                chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].e_wd);
            end
            chk($sformatf("tbl%0d_pend", i), pend_mask, tbl[i].e_pend);
            chk($sformatf("tbl%0d_ready", i), 32'(lu_ready),
                32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_hold", i), 32'(ws_hold),
                32'(tbl[i].e_hold));
            drv(tbl[i].wv, tbl[i].we, tbl[i].wa, tbl[i].wd,
                tbl[i].lv, tbl[i].la, tbl[i].ld);
            tick();
        end

        // Simultaneous push/pop: r9 queued, r10 pushed while r9 pops.
        drv(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
        tick();
        drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1010);
        tick();
        chk("pp_we9", 32'(rf_we), 32'd1);
        chk("pp_a9", 32'(rf_waddr), 32'd9);
        chk("pp_d9", rf_wdata, 32'h99);
        chk("pp_pend", pend_mask, 32'h600);
        chk("pp_ready", 32'(lu_ready), 32'd1);
        idle();
        tick();
        chk("pp_we10", 32'(rf_we), 32'd1);
        chk("pp_a10", 32'(rf_waddr), 32'd10);
        chk("pp_d10", rf_wdata, 32'h1010);
        tick();
        chk("pp_end", 32'(rf_we), 32'd0);

        // r0 discard: the r0 slot costs one cycle with no write.
        drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD0);
        tick();
        chk("r0_pend1", pend_mask, 32'h0);
        drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h2222);
        tick();
        chk("r0_slot_we", 32'(rf_we), 32'd0);
        chk("r0_pend2", pend_mask, 32'h4);
        idle();
        tick();
        chk("r0_we2", 32'(rf_we), 32'd1);
        chk("r0_a2", 32'(rf_waddr), 32'd2);
        chk("r0_d2", rf_wdata, 32'h2222);
        chk("r0_pend3", pend_mask, 32'h4);
        tick();
        chk("r0_end", 32'(rf_we), 32'd0);
        chk("r0_pend4", pend_mask, 32'h0);

        // Contention: ws busy every cycle until the hold request is honored.
        drv(1'b1, 1'b1, 5'd16, 32'h160, 1'b1, 5'd3, 32'h33);
        tick();
        chk("ct_ready_b", 32'(lu_ready), 32'd1);
        drv(1'b1, 1'b1, 5'd17, 32'h170, 1'b1, 5'd4, 32'h44);
        tick();
        chk("ct_full", 32'(lu_ready), 32'd0);
        chk("ct_hold1", 32'(ws_hold), 32'd0);
        drv(1'b1, 1'b1, 5'd18, 32'h180, 1'b0, 5'd0, 32'd0);
        tick();
        chk("ct_hold2", 32'(ws_hold), 32'd0);
        drv(1'b1, 1'b1, 5'd19, 32'h190, 1'b0, 5'd0, 32'd0);
        tick();
        chk("ct_hold3", 32'(ws_hold), 32'd0);
        chk("ct_pend", pend_mask, 32'h80018);
        drv(1'b1, 1'b1, 5'd20, 32'h200, 1'b0, 5'd0, 32'd0);
        tick();
        chk("ct_hold4", 32'(ws_hold), 32'd1);
        chk("ct_full4", 32'(lu_ready), 32'd0);
        idle();
        tick();
        chk("ct_we3", 32'(rf_we), 32'd1);
        chk("ct_a3", 32'(rf_waddr), 32'd3);
        chk("ct_d3", rf_wdata, 32'h33);
        chk("ct_hold_drop", 32'(ws_hold), 32'd0);
        chk("ct_ready", 32'(lu_ready), 32'd1);
        tick();
        chk("ct_a4", 32'(rf_waddr), 32'd4);
        chk("ct_we4", 32'(rf_we), 32'd1);
        tick();
        tick();

        // Asynchronous reset with two entries queued.
        drv(1'b1, 1'b1, 5'd21, 32'h210, 1'b1, 5'd11, 32'hB1);
        tick();
        drv(1'b1, 1'b1, 5'd22, 32'h220, 1'b1, 5'd12, 32'hB2);
        tick();
        chk("rs_full", 32'(lu_ready), 32'd0);
        chk("rs_busy", 32'(rf_we), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_vals("async");
        m_reset();
        idle();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rs_quiet%0d", i), 32'(rf_we), 32'd0);
            tick();
        end

        // Randomized traffic against the model.
        hold_lu = 1'b0;
        h_la    = '0;
        h_ld    = '0;
        for (int c = 0; c < 600; c++) begin
            logic wv, we, lv;
            logic [31:0] pm;
            pm = m_pend();
            wv = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 4) != 0);
            a  = 5'($urandom_range(0, 31));
            if (pm[a]) we = 1'b0;
            if (m_starve == LIMIT && $urandom_range(0, 3) != 0) wv = 1'b0;
            if (hold_lu) begin
                lv = 1'b1;
            end else begin
                lv   = ($urandom_range(0, 2) == 0);
                h_la = ($urandom_range(0, 7) == 0) ? 5'd0
                                                   : 5'($urandom_range(1, 31));
                h_ld = $urandom;
            end
            drv(wv, we, a, $urandom, lv, h_la, h_ld);
            hold_lu = lv && !lu_ready;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter for the 32x32 register file. It merges the pipeline writeback stream with results from long-latency units such as the multiplier/divider and load miss return. Long-latency results are buffered in a small FIFO so they can be written onto the file's single write port. The block also exports a pending-destination mask to the hazard unit and can request a pipeline bubble when a buffered result is starving.

## Interface
- DEPTH, 2: long-latency FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 4: cycles a non-empty FIFO head may wait before `ws_hold` asserts

- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- ws_valid  in  1  pipeline writeback valid; never back-pressured
- ws_we  in  1  pipeline writeback writes a register
- ws_waddr  in  5  pipeline destination
- ws_wdata  in  32  pipeline result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept; equals (count < DEPTH)
- lu_waddr  in  5  long-latency destination
- lu_wdata  in  32  long-latency result
- rf_we  out  1  to regfile `we`, registered
- rf_waddr  out  5  to regfile `waddr`, registered
- rf_wdata  out  32  to regfile `wdata`, registered
- pend_mask  out  32  bit i = write to ri buffered or in output register
- ws_hold  out  1  request one pipeline writeback bubble

## Operation
- Push: `lu_valid & lu_ready` → entry {waddr, wdata} enqueued at tail. The producer holds its data while `lu_ready`=0.
- Per-cycle selection, in priority order:
  - (a) `ws_valid & ws_we & ws_waddr!=0` → load output register from ws.
  - (b) else, if FIFO non-empty → pop head and load output register from it.
  - (c) else → `rf_we`=0.
- ws with `ws_we`=0 or `ws_waddr`=0 does not occupy the port. The FIFO may pop that cycle.
- FIFO head with `waddr`=0 is popped and discarded: `rf_we`=0 for that slot, no pend bit.
- Push and pop in the same cycle are allowed. Count is unchanged.
- `lu_ready` depends on current count only, so no push occurs while full, even if a pop happens that cycle.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - `ws_hold` = (counter == STARVE_LIMIT).
  - The pipeline answers with one cycle of `ws_valid`=0 or `ws_we`=0.
  - If ws still writes, ws wins (rule a) and `ws_hold` stays high.
- `pend_mask`: combinational OR of one-hot(waddr) over valid FIFO entries with nonzero waddr, ORed with one-hot(`rf_waddr`) when `rf_we`=1. Bit 0 is always 0.
- WAW precondition, enforced upstream: no ws write to a register whose `pend_mask` bit is set. The arbiter does no ordering check.
- FIFO entries are written exactly once each. None are dropped, duplicated or reordered.

## Timing
- Reset values while `resetn`=0:
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0
  - FIFO count=0, pointers=0
  - starve counter=0
  - `lu_ready`=1, `pend_mask`=0, `ws_hold`=0
- Reset asserted mid-operation flushes all buffered entries. No write issues after the reset edge.
- ws latency: qualifying ws in cycle N → `rf_we`=1 with that addr/data during N+1. The regfile captures at the end of N+1.
- lu latency, empty FIFO and no ws conflict: push in cycle N → popped in N+1 → `rf_we`=1 in N+2.
- `pend_mask` bit for a pushed entry sets in N+1 and clears after the cycle in which `rf_we` shows it.
- Throughput: one regfile write per cycle maximum.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH.

## Test plan
- Reset: apply `resetn`=0 asynchronously with 2 entries queued → outputs immediately at reset values, `lu_ready`=1. After release, no `rf_we` until new input arrives.
- ws path: cycle N ws_valid=1, ws_we=1, waddr=5, wdata=0x12345678 → cycle N+1 rf_we=1, rf_waddr=5, rf_wdata=0x12345678. With waddr=0 → rf_we=0 in N+1.
- lu path: push waddr=7, wdata=0xA5A5A5A5 in cycle N, idle ws → pend_mask=0x80 in N+1..N+2, rf_we=1 with that data in N+2, pend_mask=0 in N+3.
- Contention/full: ws writes every cycle; push waddr 3 then 4 → lu_ready=0 after the second push. ws_hold=1 once the head has waited STARVE_LIMIT=4 cycles. ws idles one cycle → r3 written next cycle, ws_hold drops, lu_ready=1.
- Simultaneous push/pop: count=1 holding r9, idle ws, push r10 in the same cycle → r9 written next cycle, count stays 1, r10 written the following cycle, in order.
- r0 discard: push waddr=0 then waddr=2 → only r2 is written. pend_mask bit0 never set, and the r0 slot consumes one cycle with rf_we=0.
